// File: rtl/video_in_bt656_stream_if.sv
// Luma sample stream leaving the BT.656 extractor: FIFO head plus start-of-field
// and end-of-line tags, with a valid/ready handshake.
interface video_in_bt656_stream_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop;
    logic             out_eol;

    modport master (output out_data, out_valid, out_sop, out_eol, input out_ready);
    modport slave  (input out_data, out_valid, out_sop, out_eol, output out_ready);
endinterface

// File: rtl/video_in_bt656_stream.sv
// BT.656 luma extractor: parses EAV/SAV timing codes, keeps (decimated) luma of
// admitted fields and queues it with sop/eol tags in a first-word-fall-through FIFO.
module video_in_bt656_stream #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACTIVE   = 720,
    parameter int DECIM      = 1,
    parameter int FIELD_SEL  = 0
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [DATA_W-1:0]           td_data,
    video_in_bt656_stream_if.master     st,
    output logic                        field,
    output logic                        overflow_flag,
    input  logic                        overflow_clr,
    output logic                        short_line
);
    localparam int LC_W = $clog2(H_ACTIVE + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = OUT_W + 2;
    localparam logic [LC_W-1:0] H_LIM   = LC_W'(H_ACTIVE);
    localparam logic [LC_W-1:0] EOL_IDX = LC_W'(H_ACTIVE - DECIM);
    localparam logic [LC_W-1:0] DMASK   = LC_W'(DECIM - 1);

    typedef enum logic [1:0] {HUNT, P1, P2, P3} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] b_p0;
    logic              in_active, line_open, vblank_seen, sop_arm;
    logic [1:0]        phase;
    logic [LC_W-1:0]   lc;
    logic              is_ff, is_00, code_vld, code_f, code_v, code_h, admit;
    logic              luma, keep, eol_tag;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, empty, push, pop, drop;
    logic [EW-1:0]     head;

    // Stage p0: input byte register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) b_p0 <= '0;
        else                b_p0 <= td_data;
    end

    assign is_ff    = (b_p0 == {DATA_W{1'b1}});
    assign is_00    = (b_p0 == '0);
    assign code_vld = (state == P3) && b_p0[7];
    assign code_f   = b_p0[6];
    assign code_v   = b_p0[5];
    assign code_h   = b_p0[4];
    assign admit    = (FIELD_SEL == 0) || (FIELD_SEL == 1 && !code_f) || (FIELD_SEL == 2 && code_f);
    assign eol_tag  = (lc == EOL_IDX);

    // Any FF may open a new preamble, so FF FF 00 00 XY still locks
    always_comb begin
        state_nxt  = state;
        luma       = 1'b0;
        keep       = 1'b0;
        short_line = 1'b0;
        unique case (state)
            HUNT:    state_nxt = is_ff ? P1 : HUNT;
            P1:      state_nxt = is_00 ? P2 : (is_ff ? P1 : HUNT);
            P2:      state_nxt = is_00 ? P3 : (is_ff ? P1 : HUNT);
            P3:      state_nxt = is_ff ? P1 : HUNT;
            default: state_nxt = HUNT;
        endcase
        luma       = in_active && !is_ff && phase[0];
        keep       = luma && (lc < H_LIM) && ((lc & DMASK) == '0);
        short_line = code_vld && code_h && line_open && (lc < H_LIM);
    end

    // Stage p1: timing-code decode and active-region tracking
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= HUNT;
            in_active   <= 1'b0;
            line_open   <= 1'b0;
            vblank_seen <= 1'b0;
            sop_arm     <= 1'b0;
            phase       <= '0;
            lc          <= '0;
            field       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (code_vld) begin
                in_active <= 1'b0;
                if (code_h) begin
                    line_open <= 1'b0;
                end else if (code_v) begin
                    vblank_seen <= 1'b1;
                    line_open   <= 1'b0;
                end else begin
                    field       <= code_f;
                    in_active   <= admit;
                    line_open   <= admit;
                    phase       <= '0;
                    lc          <= '0;
                    vblank_seen <= 1'b0;
                    if (admit && vblank_seen) sop_arm <= 1'b1;
                end
            end else if (in_active) begin
                if (is_ff) begin
                    in_active <= 1'b0;
                end else begin
                    phase <= phase + 2'd1;
                    if (phase[0] && lc < H_LIM) lc <= lc + 1'b1;
                    if (keep) sop_arm <= 1'b0;
                end
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign pop   = st.out_valid && st.out_ready;
    assign push  = keep && (!full || pop);
    assign drop  = keep && full && !pop;

    // Stage p2: FIFO write; a dropped sample takes its sop/eol tag with it
    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sop_arm, eol_tag, b_p0[DATA_W-1 -: OUT_W]};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)              overflow_flag <= 1'b1;
            else if (overflow_clr) overflow_flag <= 1'b0;
        end
    end

    assign head         = mem[rd_ptr[AW-1:0]];
    assign st.out_valid = !empty;
    assign st.out_data  = empty ? '0 : head[OUT_W-1:0];
    assign st.out_sop   = !empty && head[EW-1];
    assign st.out_eol   = !empty && head[EW-2];
endmodule

// File: tb/tb_video_in_bt656_stream.sv
// Bench for video_in_bt656_stream: two configurations share one BT.656 byte stream
// and are scored against a line-level model of which luma samples must come out.
module tb_video_in_bt656_stream;
    localparam int H     = 720;
    localparam int DEPTH = 16;
    localparam int BIG   = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [7:0] td    = 8'h00;
    logic       clr   = 1'b0;
    logic       field_a, field_b, ovf_a, ovf_b, short_a, short_b;

    video_in_bt656_stream_if #(.OUT_W(8)) st_a ();
    video_in_bt656_stream_if #(.OUT_W(4)) st_b ();

    video_in_bt656_stream #(.OUT_W(8), .FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .DECIM(1), .FIELD_SEL(0)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .td_data(td), .st(st_a),
        .field(field_a), .overflow_flag(ovf_a), .overflow_clr(clr), .short_line(short_a));

    video_in_bt656_stream #(.OUT_W(4), .FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .DECIM(4), .FIELD_SEL(1)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .td_data(td), .st(st_b),
        .field(field_b), .overflow_flag(ovf_b), .overflow_clr(clr), .short_line(short_b));

    int tests = 0;
    int fails = 0;

    // Reference model state: per-configuration parameters, expected samples {sop,eol,data}
    int          m_dec [2] = '{1, 4};
    int          m_w   [2] = '{8, 4};
    int          m_fs  [2] = '{0, 1};
    int          cap   [2] = '{BIG, BIG};
    bit          arm   [2] = '{1'b0, 1'b0};
    bit          vbs   [2] = '{1'b0, 1'b0};
    logic [9:0]  q_a[$];
    logic [9:0]  q_b[$];
    logic [7:0]  ybuf[$];
    logic [7:0]  lb[$];
    int          pops_b   = 0;
    int          shorts_a = 0;
    int          shorts_b = 0;

    always @(negedge clk) begin
        logic [9:0] got, exp;
        if (rst_n && st_a.out_valid && st_a.out_ready) begin
            tests++;
            got = {st_a.out_sop, st_a.out_eol, st_a.out_data};
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL sample_a: got unexpected %h, required no sample", got);
            end else begin
                exp = q_a.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL sample_a: got %h, required %h", got, exp);
                end
            end
        end
        if (rst_n && st_b.out_valid && st_b.out_ready) begin
            tests++;
            pops_b++;
            got = {st_b.out_sop, st_b.out_eol, 4'h0, st_b.out_data};
            if (q_b.size() == 0) begin
                fails++;
                $display("FAIL sample_b: got unexpected %h, required no sample", got);
            end else begin
                exp = q_b.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL sample_b: got %h, required %h", got, exp);
                end
            end
        end
        if (short_a === 1'b1) shorts_a++;
        if (short_b === 1'b1) shorts_b++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xy(bit f, bit v, bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic send_byte(input logic [7:0] x);
        @(posedge clk);
        #1 td = x;
    endtask

    task automatic send_code(input bit f, input bit v, input bit h);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(xy(f, v, h));
    endtask

    task automatic send_blank(input int n);
        for (int i = 0; i < n; i++) send_byte((i % 2 == 0) ? 8'h80 : 8'h10);
    endtask

    // mode 0: random luma, 1: ramp from 0x10, 2: constant 0xAB; chroma always random
    task automatic build_line(input int n, input int mode);
        logic [7:0] y;
        ybuf.delete();
        lb.delete();
        for (int i = 0; i < n; i++) begin
            y = (mode == 0) ? 8'($urandom_range(1, 254)) : (mode == 1) ? 8'(16 + (i % 224)) : 8'hAB;
            ybuf.push_back(y);
            lb.push_back(8'($urandom_range(1, 254)));
            lb.push_back(y);
        end
    endtask

    task automatic model_line(input bit f, input int n);
        bit         adm;
        logic [9:0] ent;
        logic [7:0] dv;
        for (int d = 0; d < 2; d++) begin
            adm = (m_fs[d] == 0) || (m_fs[d] == 1 && !f) || (m_fs[d] == 2 && f);
            if (adm) begin
                if (vbs[d]) arm[d] = 1'b1;
                for (int i = 0; i < n; i++) begin
                    if (i < H && i % m_dec[d] == 0) begin
                        dv  = ybuf[i] >> (8 - m_w[d]);
                        ent = {arm[d], (i == H - m_dec[d]), dv};
                        arm[d] = 1'b0;
                        if (qsize(d) < cap[d]) begin
                            if (d == 0) q_a.push_back(ent);
                            else        q_b.push_back(ent);
                        end
                    end
                end
            end
            vbs[d] = 1'b0;
        end
    endtask

    task automatic model_reset();
        q_a.delete(); q_b.delete();
        for (int d = 0; d < 2; d++) begin arm[d] = 1'b0; vbs[d] = 1'b0; end
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) send_byte(lb[j]);
    endtask

    task automatic start_line(input bit f, input int n, input int mode);
        build_line(n, mode);
        model_line(f, n);
        send_code(f, 1'b0, 1'b0);
    endtask

    task automatic finish_line(input bit f);
        send_code(f, 1'b0, 1'b1);
        send_blank(8);
    endtask

    task automatic play_line(input bit f, input int n, input int mode);
        start_line(f, n, mode);
        send_range(0, lb.size() - 1);
        finish_line(f);
    endtask

    task automatic play_vblank(input bit f);
        vbs[0] = 1'b1; vbs[1] = 1'b1;
        send_code(f, 1'b1, 1'b0);
        send_blank(8);
        send_code(f, 1'b1, 1'b1);
        send_blank(8);
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        ok = (q_a.size() == 0) && (q_b.size() == 0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (st_a.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", st_a.out_valid); end
        tests++; if (st_a.out_sop !== 1'b0) begin fails++; $display("FAIL reset_sop: got %b, required 0", st_a.out_sop); end
        tests++; if (st_a.out_eol !== 1'b0) begin fails++; $display("FAIL reset_eol: got %b, required 0", st_a.out_eol); end
        tests++; if (st_a.out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", st_a.out_data); end
        tests++; if (field_a !== 1'b0) begin fails++; $display("FAIL reset_field: got %b, required 0", field_a); end
        tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", ovf_a); end
        tests++; if (short_a !== 1'b0) begin fails++; $display("FAIL reset_short: got %b, required 0", short_a); end
        tests++; if (st_b.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_b: got %b, required 0", st_b.out_valid); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        send_blank(6);
    endtask

    task automatic test_basic_line();
        bit ok;
        int s0 = shorts_a;
        play_vblank(1'b0);
        start_line(1'b0, H, 1);
        send_byte(lb[0]); send_byte(lb[1]);
        @(negedge clk);
        tests++; if (st_a.out_valid !== 1'b0) begin fails++; $display("FAIL latency_edge0: got valid %b, required 0", st_a.out_valid); end
        send_byte(lb[2]);
        @(negedge clk);
        tests++; if (st_a.out_valid !== 1'b0) begin fails++; $display("FAIL latency_edge1: got valid %b, required 0", st_a.out_valid); end
        send_byte(lb[3]);
        @(negedge clk);
        tests++; if (st_a.out_valid !== 1'b1) begin fails++; $display("FAIL latency_edge2: got valid %b, required 1", st_a.out_valid); end
        send_range(4, lb.size() - 1);
        finish_line(1'b0);
        drain(ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_drain: got %0d left, required 0", q_a.size() + q_b.size()); end
        tests++; if (st_a.out_valid !== 1'b0) begin fails++; $display("FAIL basic_empty: got valid %b, required 0", st_a.out_valid); end
        tests++; if (shorts_a != s0) begin fails++; $display("FAIL basic_short: got %0d pulses, required 0", shorts_a - s0); end
        tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL basic_overflow: got %b, required 0", ovf_a); end
    endtask

    task automatic test_decim();
        bit ok;
        pops_b = 0;
        play_vblank(1'b0);
        play_line(1'b0, H, 2);
        drain(ok);
        tests++; if (!ok) begin fails++; $display("FAIL decim_drain: got %0d left, required 0", q_a.size() + q_b.size()); end
        tests++; if (pops_b != 180) begin fails++; $display("FAIL decim_count: got %0d samples, required 180", pops_b); end
    endtask

    task automatic test_field_sel();
        bit ok;
        bit fs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit vb [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pops_b = 0;
        for (int k = 0; k < 6; k++) begin
            if (vb[k]) play_vblank(fs[k]);
            start_line(fs[k], H, 0);
            send_range(0, 1);
            @(negedge clk);
            tests++; if (field_a !== fs[k]) begin fails++; $display("FAIL field_a line %0d: got %b, required %b", k, field_a, fs[k]); end
            tests++; if (field_b !== fs[k]) begin fails++; $display("FAIL field_b line %0d: got %b, required %b", k, field_b, fs[k]); end
            send_range(2, lb.size() - 1);
            finish_line(fs[k]);
        end
        drain(ok);
        tests++; if (!ok) begin fails++; $display("FAIL field_drain: got %0d left, required 0", q_a.size() + q_b.size()); end
        tests++; if (pops_b != 540) begin fails++; $display("FAIL field_count_b: got %0d samples, required 540", pops_b); end
    endtask

    task automatic test_backpressure();
        bit ok;
        tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL bp_overflow_pre: got %b, required 0", ovf_a); end
        st_a.out_ready = 1'b0; cap[0] = DEPTH;
        play_line(1'b0, H, 0);
        @(negedge clk);
        tests++; if (ovf_a !== 1'b1) begin fails++; $display("FAIL bp_overflow_set: got %b, required 1", ovf_a); end
        tests++; if (st_a.out_valid !== 1'b1) begin fails++; $display("FAIL bp_retained: got valid %b, required 1", st_a.out_valid); end
        tests++; if (ovf_b !== 1'b0) begin fails++; $display("FAIL bp_overflow_b: got %b, required 0", ovf_b); end
        st_a.out_ready = 1'b1; cap[0] = BIG;
        drain(ok);
        tests++; if (!ok || st_a.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %0d left valid %b, required 0 left valid 0", q_a.size(), st_a.out_valid); end
        st_a.out_ready = 1'b0; cap[0] = DEPTH;
        start_line(1'b0, H, 0);
        for (int j = 0; j < lb.size(); j++) begin
            send_byte(lb[j]);
            if (j == 82) clr = 1'b1;
            if (j == 83) begin
                clr = 1'b0;
                @(negedge clk);
                tests++; if (ovf_a !== 1'b1) begin fails++; $display("FAIL bp_set_beats_clr: got %b, required 1", ovf_a); end
            end
        end
        finish_line(1'b0);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL bp_clr_alone: got %b, required 0", ovf_a); end
        st_a.out_ready = 1'b1; cap[0] = BIG;
        drain(ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_drain2: got %0d left, required 0", q_a.size() + q_b.size()); end
    endtask

    task automatic test_short_line();
        bit ok;
        int s0 = shorts_a;
        int s1 = shorts_b;
        start_line(1'b0, 100, 0);
        send_range(0, lb.size() - 1);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(xy(1'b0, 1'b0, 1'b1));
        @(negedge clk);
        tests++; if (short_a !== 1'b0) begin fails++; $display("FAIL short_before: got %b, required 0", short_a); end
        @(negedge clk);
        tests++; if (short_a !== 1'b1) begin fails++; $display("FAIL short_pulse: got %b, required 1", short_a); end
        @(negedge clk);
        tests++; if (short_a !== 1'b0) begin fails++; $display("FAIL short_after: got %b, required 0", short_a); end
        send_blank(8);
        play_line(1'b0, H, 0);
        drain(ok);
        tests++; if (!ok) begin fails++; $display("FAIL short_drain: got %0d left, required 0", q_a.size() + q_b.size()); end
        tests++; if (shorts_a - s0 != 1) begin fails++; $display("FAIL short_count_a: got %0d cycles, required 1", shorts_a - s0); end
        tests++; if (shorts_b - s1 != 1) begin fails++; $display("FAIL short_count_b: got %0d cycles, required 1", shorts_b - s1); end
    endtask

    task automatic test_reset_midline();
        bit ok;
        st_a.out_ready = 1'b0; cap[0] = DEPTH;
        start_line(1'b1, H, 0);
        send_range(0, 99);
        @(negedge clk);
        tests++; if (st_a.out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b, required 1", st_a.out_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (st_a.out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b, required 0", st_a.out_valid); end
        tests++; if (field_a !== 1'b0) begin fails++; $display("FAIL rst_async_field: got %b, required 0", field_a); end
        model_reset();
        st_a.out_ready = 1'b1; cap[0] = BIG;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        send_range(100, 399);
        build_line(H, 0);
        model_line(1'b0, H);
        send_byte(8'hFF);
        send_code(1'b0, 1'b0, 1'b0);
        send_range(0, lb.size() - 1);
        finish_line(1'b0);
        play_vblank(1'b0);
        play_line(1'b0, H, 1);
        drain(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rst_resync_drain: got %0d left, required 0", q_a.size() + q_b.size()); end
    endtask

    initial begin
        st_a.out_ready = 1'b1;
        st_b.out_ready = 1'b1;
        test_reset();
        test_basic_line();
        test_decim();
        test_field_sel();
        test_backpressure();
        test_short_line();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
